// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: turns byte-framed UART commands into single-cycle register
// bus accesses and answers each command with an ACK, NAK or read-data byte.
// Write = 0x57 addr data -> 0x06; Read = 0x52 addr -> data; anything else -> 0x15.
// Optional inter-byte timeout: define UART_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  input  logic                  rxParityError,
  output logic [7:0]            txData,
  output logic                  txStart,
  input  logic                  txBusy,
  input  logic                  txDone,
  output logic [ADDR_WIDTH-1:0] regAddr,
  output logic [DATA_WIDTH-1:0] regWdata,
  output logic                  regWe,
  output logic                  regRe,
  input  logic [DATA_WIDTH-1:0] regRdata,
  output logic                  busy,
  output logic                  cmdError
);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    READ_WAIT,
    SEND,
    WAIT_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    isWrite_q, isWrite_d;
  logic [7:0]              txData_q, txData_d;
  logic                    txStart_q, txStart_d;
  logic [ADDR_WIDTH-1:0]   regAddr_q, regAddr_d;
  logic [DATA_WIDTH-1:0]   regWdata_q, regWdata_d;
  logic                    regWe_q, regWe_d;
  logic                    regRe_q, regRe_d;
  logic                    busy_q, busy_d;
  logic                    cmdError_q, cmdError_d;
  logic                    timeoutHit;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] timer_q, timer_d;

  // Countdown of idle cycles while waiting for the next command byte; any
  // received byte or any other state reloads it.
  always_comb begin
    timer_d = TW'(TIMEOUT_CYCLES - 1);
    if ((state_q == GET_ADDR || state_q == GET_DATA) && !rxValid && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= TW'(TIMEOUT_CYCLES - 1);
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timeoutHit = (timer_q == '0);
`else
  assign timeoutHit = 1'b0;
`endif

  // Command sequencer: next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    isWrite_d  = isWrite_q;
    txData_d   = txData_q;
    txStart_d  = 1'b0;
    regAddr_d  = regAddr_q;
    regWdata_d = regWdata_q;
    regWe_d    = 1'b0;
    regRe_d    = 1'b0;
    cmdError_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rxValid) begin
          if (!rxParityError && (rxData == OP_WRITE || rxData == OP_READ)) begin
            isWrite_d = (rxData == OP_WRITE);
            state_d   = GET_ADDR;
          end else begin
            txData_d   = REPLY_NAK;
            cmdError_d = 1'b1;
            state_d    = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rxValid) begin
          if (rxParityError) begin
            txData_d   = REPLY_NAK;
            cmdError_d = 1'b1;
            state_d    = SEND;
          end else begin
            regAddr_d = rxData[ADDR_WIDTH-1:0];
            if (isWrite_q) begin
              state_d = GET_DATA;
            end else begin
              regRe_d = 1'b1;
              state_d = READ;
            end
          end
        end else if (timeoutHit) begin
          cmdError_d = 1'b1;
          state_d    = IDLE;
        end
      end
      GET_DATA: begin
        if (rxValid) begin
          if (rxParityError) begin
            txData_d   = REPLY_NAK;
            cmdError_d = 1'b1;
            state_d    = SEND;
          end else begin
            regWdata_d = DATA_WIDTH'(rxData);
            regWe_d    = 1'b1;
            state_d    = WRITE;
          end
        end else if (timeoutHit) begin
          cmdError_d = 1'b1;
          state_d    = IDLE;
        end
      end
      WRITE: begin
        txData_d = REPLY_ACK;
        if (!txBusy) begin
          txStart_d = 1'b1;
          state_d   = WAIT_DONE;
        end else begin
          state_d = SEND;
        end
      end
      READ: begin
        state_d = READ_WAIT;
      end
      READ_WAIT: begin
        txData_d = 8'(regRdata);
        if (!txBusy) begin
          txStart_d = 1'b1;
          state_d   = WAIT_DONE;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!txBusy) begin
          txStart_d = 1'b1;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (txDone) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      isWrite_q  <= 1'b0;
      txData_q   <= '0;
      txStart_q  <= 1'b0;
      regAddr_q  <= '0;
      regWdata_q <= '0;
      regWe_q    <= 1'b0;
      regRe_q    <= 1'b0;
      busy_q     <= 1'b0;
      cmdError_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      isWrite_q  <= isWrite_d;
      txData_q   <= txData_d;
      txStart_q  <= txStart_d;
      regAddr_q  <= regAddr_d;
      regWdata_q <= regWdata_d;
      regWe_q    <= regWe_d;
      regRe_q    <= regRe_d;
      busy_q     <= busy_d;
      cmdError_q <= cmdError_d;
    end
  end

  assign txData   = txData_q;
  assign txStart  = txStart_q;
  assign regAddr  = regAddr_q;
  assign regWdata = regWdata_q;
  assign regWe    = regWe_q;
  assign regRe    = regRe_q;
  assign busy     = busy_q;
  assign cmdError = cmdError_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Testbench for uart_reg_bridge: directed and randomized commands, checked
// against a register-file reference model and the command timing rules.
module tb_uart_reg_bridge;

  localparam int TOUT = 100;

  typedef struct {
    int a;
    int d;
    int c;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxParityError;
  logic [7:0] txData;
  logic       txStart;
  logic       txBusy;
  logic       txDone;
  logic [7:0] regAddr;
  logic [7:0] regWdata;
  logic       regWe;
  logic       regRe;
  logic [7:0] regRdata = 8'h00;
  logic       busy;
  logic       cmdError;

  logic       txBusyM;
  logic       holdBusy;
  int         txCnt;

  bit [7:0]   slaveMem [256];
  bit [7:0]   refMem [256];
  int         writtenAddrs[$];

  ev_t        weQ[$];
  ev_t        reQ[$];
  ev_t        txQ[$];
  ev_t        errQ[$];
  int         cycN = 0;
  int         protoViol = 0;
  logic [7:0] txHeld = 8'h00;

  int         vectors = 0;
  int         miscompares = 0;

  uart_reg_bridge #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rxData(rxData),
    .rxValid(rxValid),
    .rxParityError(rxParityError),
    .txData(txData),
    .txStart(txStart),
    .txBusy(txBusy),
    .txDone(txDone),
    .regAddr(regAddr),
    .regWdata(regWdata),
    .regWe(regWe),
    .regRe(regRe),
    .regRdata(regRdata),
    .busy(busy),
    .cmdError(cmdError)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  assign txBusy = txBusyM | holdBusy;

  // Transmitter model: busy for a few cycles after each start, then a done strobe.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txBusyM <= 1'b0;
      txDone  <= 1'b0;
      txCnt   <= 0;
    end else begin
      txDone <= 1'b0;
      if (txStart) begin
        txBusyM <= 1'b1;
        txCnt   <= 6;
      end else if (txBusyM) begin
        if (txCnt == 0) begin
          txBusyM <= 1'b0;
          txDone  <= 1'b1;
        end else begin
          txCnt <= txCnt - 1;
        end
      end
    end
  end

  // Register slave: write on regWe, read data returned the cycle after regRe.
  always @(posedge clk) begin
    if (regWe) slaveMem[regAddr] <= regWdata;
    if (regRe) regRdata <= slaveMem[regAddr];
  end

  // Event monitor sampling on the falling edge; records strobes with cycle stamps.
  always @(negedge clk) begin
    cycN = cycN + 1;
    if (regWe) weQ.push_back('{int'(regAddr), int'(regWdata), cycN});
    if (regRe) reQ.push_back('{int'(regAddr), 0, cycN});
    if (txStart) begin
      txQ.push_back('{0, int'(txData), cycN});
      txHeld = txData;
    end
    if (cmdError) errQ.push_back('{0, 0, cycN});
    if (regWe && regRe) protoViol++;
    if (txStart && txBusy) protoViol++;
    if (txBusyM && txData !== txHeld) protoViol++;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic par, output int t);
    @(posedge clk);
    #1;
    rxData        = b;
    rxValid       = 1'b1;
    rxParityError = par;
    t             = cycN + 1;
    @(posedge clk);
    #1;
    rxValid       = 1'b0;
    rxParityError = 1'b0;
    rxData        = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy === 1'b1 && n < 1000);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expectOne(input string tag, input ev_t q[$], input int base,
                           input bit chkA, input int expA, input bit chkD, input int expD,
                           input int expC);
    checkOutput({tag, "_count"}, q.size() - base, 1);
    if (q.size() - base == 1) begin
      if (chkA) checkOutput({tag, "_addr"}, q[base].a, expA);
      if (chkD) checkOutput({tag, "_data"}, q[base].d, expD);
      checkOutput({tag, "_cycle"}, q[base].c, expC);
    end
  endtask

  task automatic expectNone(input string tag, input ev_t q[$], input int base);
    checkOutput({tag, "_none"}, q.size() - base, 0);
  endtask

  // kind: 0 write, 1 read, 2 bad opcode, 3 write with parity error on byte parPos.
  task automatic runCommand(input int kind, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] opc, input int parPos);
    int t;
    int wb = weQ.size();
    int rb = reQ.size();
    int tb = txQ.size();
    int eb = errQ.size();
    logic [7:0] bytes [3];
    bytes[0] = 8'h57;
    bytes[1] = addr;
    bytes[2] = data;
    case (kind)
      0: begin
        applyStimulus(8'h57, 1'b0, t);
        applyStimulus(addr, 1'b0, t);
        applyStimulus(data, 1'b0, t);
        waitIdle("wr");
        refMem[addr] = data;
        writtenAddrs.push_back(int'(addr));
        expectOne("wr_we", weQ, wb, 1'b1, int'(addr), 1'b1, int'(data), t + 1);
        expectNone("wr_re", reQ, rb);
        expectOne("wr_tx", txQ, tb, 1'b0, 0, 1'b1, 32'h06, t + 2);
        expectNone("wr_err", errQ, eb);
      end
      1: begin
        applyStimulus(8'h52, 1'b0, t);
        applyStimulus(addr, 1'b0, t);
        waitIdle("rd");
        expectNone("rd_we", weQ, wb);
        expectOne("rd_re", reQ, rb, 1'b1, int'(addr), 1'b0, 0, t + 1);
        expectOne("rd_tx", txQ, tb, 1'b0, 0, 1'b1, int'(refMem[addr]), t + 3);
        expectNone("rd_err", errQ, eb);
      end
      2: begin
        applyStimulus(opc, 1'b0, t);
        waitIdle("bad");
        expectNone("bad_we", weQ, wb);
        expectNone("bad_re", reQ, rb);
        expectOne("bad_err", errQ, eb, 1'b0, 0, 1'b0, 0, t + 1);
        expectOne("bad_tx", txQ, tb, 1'b0, 0, 1'b1, 32'h15, t + 2);
      end
      default: begin
        for (int i = 0; i < parPos; i++) applyStimulus(bytes[i], 1'b0, t);
        applyStimulus(bytes[parPos], 1'b1, t);
        waitIdle("par");
        expectNone("par_we", weQ, wb);
        expectNone("par_re", reQ, rb);
        expectOne("par_err", errQ, eb, 1'b0, 0, 1'b0, 0, t + 1);
        expectOne("par_tx", txQ, tb, 1'b0, 0, 1'b1, 32'h15, t + 2);
      end
    endcase
  endtask

  // Directed sequence followed by randomized commands.
  initial begin
    int t;
    int n;
    int wb, rb, tb, eb;
    logic [7:0] a, d, o;
    int kind;

    resetn        = 1'b0;
    rxData        = 8'h00;
    rxValid       = 1'b0;
    rxParityError = 1'b0;
    holdBusy      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_txData", {24'd0, txData}, 32'd0);
    checkOutput("rst_txStart", {31'd0, txStart}, 32'd0);
    checkOutput("rst_regAddr", {24'd0, regAddr}, 32'd0);
    checkOutput("rst_regWdata", {24'd0, regWdata}, 32'd0);
    checkOutput("rst_regWe", {31'd0, regWe}, 32'd0);
    checkOutput("rst_regRe", {31'd0, regRe}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cmdError", {31'd0, cmdError}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] directed commands");
    runCommand(0, 8'h10, 8'hA5, 8'h00, 0);
    runCommand(1, 8'h10, 8'h00, 8'h00, 0);
    runCommand(0, 8'h22, 8'h3C, 8'h00, 0);
    runCommand(1, 8'h22, 8'h00, 8'h00, 0);
    runCommand(2, 8'h00, 8'h00, 8'h41, 0);
    runCommand(3, 8'h05, 8'h06, 8'h00, 1);
    runCommand(0, 8'h01, 8'h02, 8'h00, 0);

    $display("[TB] transmitter held busy");
    holdBusy = 1'b1;
    tb = txQ.size();
    applyStimulus(8'h52, 1'b0, t);
    applyStimulus(8'h01, 1'b0, t);
    repeat (50) @(posedge clk);
    checkOutput("hold_noStart", txQ.size() - tb, 0);
    #1 holdBusy = 1'b0;
    t = cycN + 1;
    waitIdle("hold");
    expectOne("hold_tx", txQ, tb, 1'b0, 0, 1'b1, int'(refMem[8'h01]), t + 1);

    $display("[TB] byte during WAIT_DONE is dropped");
    wb = weQ.size();
    rb = reQ.size();
    tb = txQ.size();
    applyStimulus(8'h57, 1'b0, t);
    applyStimulus(8'h33, 1'b0, t);
    applyStimulus(8'h44, 1'b0, t);
    refMem[8'h33] = 8'h44;
    n = 0;
    while (txQ.size() == tb && n < 100) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(8'h52, 1'b0, t);
    waitIdle("drop");
    repeat (10) @(negedge clk);
    checkOutput("drop_busy", {31'd0, busy}, 32'd0);
    checkOutput("drop_we", weQ.size() - wb, 1);
    checkOutput("drop_re", reQ.size() - rb, 0);
    checkOutput("drop_tx", txQ.size() - tb, 1);

    $display("[TB] reset mid-command");
    wb = weQ.size();
    tb = txQ.size();
    applyStimulus(8'h57, 1'b0, t);
    applyStimulus(8'h66, 1'b0, t);
    #1 resetn = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_regAddr", {24'd0, regAddr}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midrst_we", weQ.size() - wb, 0);
    checkOutput("midrst_tx", txQ.size() - tb, 0);
    checkOutput("midrst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] inter-byte timeout");
    wb = weQ.size();
    tb = txQ.size();
    eb = errQ.size();
    applyStimulus(8'h57, 1'b0, t);
    repeat (TOUT + 10) @(negedge clk);
`ifdef UART_BRIDGE_TIMEOUT_EN
    expectOne("tout_err", errQ, eb, 1'b0, 0, 1'b0, 0, t + TOUT + 1);
    checkOutput("tout_busy", {31'd0, busy}, 32'd0);
    expectNone("tout_tx", txQ, tb);
`else
    checkOutput("notout_busy", {31'd0, busy}, 32'd1);
    expectNone("notout_err", errQ, eb);
    applyStimulus(8'h77, 1'b0, t);
    applyStimulus(8'h99, 1'b0, t);
    refMem[8'h77] = 8'h99;
    waitIdle("notout");
    expectOne("notout_we", weQ, wb, 1'b1, 32'h77, 1'b1, 32'h99, t + 1);
    expectOne("notout_tx", txQ, tb, 1'b0, 0, 1'b1, 32'h06, t + 2);
`endif

    $display("[TB] randomized commands");
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind <= 3) begin
        runCommand(0, a, d, 8'h00, 0);
      end else if (kind <= 6) begin
        if (writtenAddrs.size() > 0 && $urandom_range(0, 3) != 0)
          a = 8'(writtenAddrs[$urandom_range(0, writtenAddrs.size() - 1)]);
        runCommand(1, a, d, 8'h00, 0);
      end else if (kind <= 8) begin
        do o = 8'($urandom); while (o == 8'h57 || o == 8'h52);
        runCommand(2, a, d, o, 0);
      end else begin
        runCommand(3, a, d, 8'h00, $urandom_range(0, 2));
      end
    end

    checkOutput("protocol_violations", protoViol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Command controller between the UART transceiver and the chip's configuration register bus. It parses byte-framed read/write commands from the receiver and issues single-cycle register accesses. It sequences the transmitter to return an ACK, NAK or read-data byte. There is exactly one outstanding command at a time; the bridge is the sole driver of the transmitter's start/data inputs.

## Interface
Parameters:
- ADDR_WIDTH, 8, register address width (≤ 8; address byte LSBs used).
- DATA_WIDTH, 8, register data width; fixed equal to the UART WIDTH (8).
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout in clk cycles (used only with timeout compiled in).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- rxData  in  8  received byte from the transceiver.
- rxValid  in  1  one-cycle strobe: rxData valid.
- rxParityError  in  1  parity error flag, qualified by rxValid.
- txData  out  8  byte to transmit; held stable from txStart until txDone.
- txStart  out  1  one-cycle transmit start pulse.
- txBusy  in  1  transmitter busy.
- txDone  in  1  one-cycle transmit complete strobe.
- regAddr  out  ADDR_WIDTH  register address.
- regWdata  out  DATA_WIDTH  register write data.
- regWe  out  1  one-cycle write strobe.
- regRe  out  1  one-cycle read strobe.
- regRdata  in  DATA_WIDTH  read data, valid the cycle after regRe.
- busy  out  1  high whenever state ≠ IDLE.
- cmdError  out  1  one-cycle pulse on NAK-generating error or timeout.

## Operation
- Protocol: write = 0x57, addr, data → reply 0x06 (ACK). Read = 0x52, addr → reply data byte. Any other opcode → reply 0x15 (NAK).
- States: IDLE, GET_ADDR, GET_DATA, WRITE, READ, READ_WAIT, SEND, WAIT_DONE.
- IDLE: on rxValid, opcode 0x57 or 0x52 → GET_ADDR (opcode latched); else → SEND with NAK, pulse cmdError.
- GET_ADDR: on rxValid, latch regAddr; write → GET_DATA, read → READ.
- GET_DATA: on rxValid, latch regWdata → WRITE.
- WRITE: regWe = 1 for this cycle; load ACK → SEND.
- READ: regRe = 1 for this cycle → READ_WAIT.
- READ_WAIT: capture regRdata into txData → SEND.
- SEND: if txBusy = 0, pulse txStart → WAIT_DONE; else stay.
- WAIT_DONE: on txDone → IDLE.
- Parity error on any rxValid in IDLE/GET_ADDR/GET_DATA: the byte is discarded, the command is aborted, cmdError pulses, → SEND with NAK.
- rxValid in WRITE/READ/READ_WAIT/SEND/WAIT_DONE: the byte is dropped silently; a command is never queued.
- Unused upper address bits of the address byte are ignored.

## Timing
- Reset values: txData = 0, txStart = 0, regAddr = 0, regWdata = 0, regWe = 0, regRe = 0, busy = 0, cmdError = 0, state IDLE.
- Reset mid-operation aborts immediately; no reply is sent and no register strobe follows.
- Write: final data rxValid at cycle T → regWe at T+1 → txStart (0x06) at T+2 if txBusy = 0.
- Read: address rxValid at T → regRe at T+1 → regRdata sampled at T+2 → txStart at T+3.
- NAK: offending rxValid at T → cmdError at T+1, txStart at T+2.
- All outputs are registered. regWe and regRe are never high together and never high outside WRITE/READ.
- txStart is never asserted while txBusy = 1. txData changes only in the cycle txStart is asserted, or earlier in the same command before txStart.
- busy drops the cycle after txDone is received.

## Configuration
- UART_BRIDGE_TIMEOUT_EN defined: a counter reloads on every accepted byte. If the bridge waits in GET_ADDR/GET_DATA for TIMEOUT_CYCLES cycles, it returns to IDLE, pulses cmdError and sends no reply.
- Not defined: no counter. The bridge waits indefinitely for the next byte, and TIMEOUT_CYCLES is unused.

## Test plan
- Write: bytes 0x57, 0x10, 0xA5 → one regWe with regAddr = 0x10 and regWdata = 0xA5 one cycle after the last byte; txData = 0x06 sent.
- Read: bytes 0x52, 0x22 with regRdata = 0x3C → one regRe at regAddr = 0x22; txData = 0x3C, txStart 3 cycles after the address byte.
- Bad opcode 0x41 → cmdError pulse, NAK 0x15 sent, no regWe/regRe.
- Parity error on the address byte of a write → NAK; the following 0x57, 0x01, 0x02 command completes normally.
- txBusy held high for 50 cycles at SEND → txStart waits and asserts the first cycle txBusy = 0. A 0x52 sent during WAIT_DONE is dropped, with no extra strobe.
- With UART_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 100: send 0x57 then idle 100 cycles → cmdError, busy = 0, no tx. Without the macro, the bridge stays in GET_ADDR.
